// File: rtl/classifier_scheduler.sv
// Round-robin scheduler sharing one packet classifier engine among
// several ingress queues, with a watchdog that flushes a hung engine.

package classifier_pkg;

    typedef struct packed {
        logic [15:0] flow_id;
        logic [7:0]  proto;
        logic [7:0]  dport;
    } packet_s;

    typedef struct packed {
        logic        hit;
        logic [14:0] rule_id;
    } rule_s;

endpackage

module classifier_scheduler
    import classifier_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PKT_W   = $bits(packet_s),
    parameter int RULE_W  = $bits(rule_s),
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] req_packet,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [PKT_W-1:0]         clf_packet,
    output logic                     clf_valid,
    input  logic                     clf_ready,
    input  logic [RULE_W-1:0]        clf_rule,
    output logic                     clf_reset,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [RULE_W-1:0]        resp_rule,
    output logic                     resp_timeout,
    output logic [15:0]              cnt_done,
    output logic [15:0]              cnt_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    SCAN_N   = (ID_W+1)'(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESPOND,
        FLUSH
    } state_e;

    state_e state;
    state_e state_nxt;

    logic             flush_cnt;
    logic             flush_to;
    logic [TMR_W-1:0] timer;
    logic [ID_W-1:0]  rr_ptr;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W:0]    scan;

    logic             accept;
    logic             done;
    logic             expire;
    logic             handoff;
    logic             flush_end;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan >= SCAN_N) begin
                scan = scan - SCAN_N;
            end
            if (!win_found && req_valid[scan[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        clf_valid  = 1'b0;
        clf_reset  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        handoff    = 1'b0;
        flush_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clf_ready && win_found) begin
                    accept            = 1'b1;
                    req_ready[win_id] = 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                clf_valid = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timer == TMR_LAST) begin
                    expire    = 1'b1;
                    state_nxt = FLUSH;
                end else if (!clf_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A done landing on the expiry cycle still counts as done.
                if (clf_ready) begin
                    done      = 1'b1;
                    state_nxt = RESPOND;
                end else if (timer == TMR_LAST) begin
                    expire    = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    handoff   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                clf_reset = 1'b1;
                if (flush_cnt) begin
                    flush_end = 1'b1;
                    state_nxt = flush_to ? RESPOND : IDLE;
                end
            end
            default: begin
                state_nxt = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt    <= 1'b0;
            flush_to     <= 1'b0;
            timer        <= '0;
            rr_ptr       <= '0;
            clf_packet   <= '0;
            resp_id      <= '0;
            resp_rule    <= '0;
            resp_timeout <= 1'b0;
            cnt_done     <= '0;
            cnt_timeout  <= '0;
        end else begin
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;

            if (accept) begin
                clf_packet <= req_packet[win_id*PKT_W +: PKT_W];
                resp_id    <= win_id;
            end

            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
                timer <= timer + 1'b1;
            end

            if (done) begin
                resp_rule    <= clf_rule;
                resp_timeout <= 1'b0;
                if (cnt_done != 16'hFFFF) begin
                    cnt_done <= cnt_done + 16'd1;
                end
            end

            if (expire) begin
                resp_rule    <= '0;
                resp_timeout <= 1'b1;
                flush_to     <= 1'b1;
                if (cnt_timeout != 16'hFFFF) begin
                    cnt_timeout <= cnt_timeout + 16'd1;
                end
            end

            if (flush_end) begin
                flush_to <= 1'b0;
            end

            if (handoff) begin
                rr_ptr <= (resp_id == ID_LAST) ? '0 : resp_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_classifier_scheduler.sv
// Bench for classifier_scheduler: per-cycle behavioural model plus
// directed scenarios with hand-computed expectations.

module tb_classifier_scheduler;

    localparam int N  = 4;
    localparam int PW = $bits(classifier_pkg::packet_s);
    localparam int RW = $bits(classifier_pkg::rule_s);
    localparam int IW = 2;
    localparam int TO = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*PW-1:0] req_packet;
    logic [N-1:0]    req_ready;
    logic [PW-1:0]   clf_packet;
    logic            clf_valid;
    logic            clf_ready;
    logic [RW-1:0]   clf_rule;
    logic            clf_reset;
    logic            resp_valid;
    logic            resp_ready;
    logic [IW-1:0]   resp_id;
    logic [RW-1:0]   resp_rule;
    logic            resp_timeout;
    logic [15:0]     cnt_done;
    logic [15:0]     cnt_timeout;

    classifier_scheduler #(
        .NUM_REQ(N),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_packet(req_packet),
        .req_ready(req_ready),
        .clf_packet(clf_packet),
        .clf_valid(clf_valid),
        .clf_ready(clf_ready),
        .clf_rule(clf_rule),
        .clf_reset(clf_reset),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id(resp_id),
        .resp_rule(resp_rule),
        .resp_timeout(resp_timeout),
        .cnt_done(cnt_done),
        .cnt_timeout(cnt_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int eng_lat = 3;

    logic [N-1:0] grant_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rule_of(input logic [PW-1:0] p);
        return {1'b1, p[14:0]};
    endfunction

    function automatic logic [N-1:0] pick(input logic [N-1:0] v,
                                          input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return N'(1) << ((rr + k) % N);
        end
        return '0;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (g[k]) return k;
        end
        return 0;
    endfunction

    // Engine model: drops ready after an issue, raises it eng_lat
    // cycles later, or as soon as it is flushed.
    initial begin
        logic [PW-1:0] e_pkt;
        int e_n;
        forever begin
            @(negedge clk);
            if (clf_valid) begin
                e_pkt = clf_packet;
                @(posedge clk);
                #1 clf_ready = 1'b0;
                e_n = 0;
                while (e_n < eng_lat) begin
                    @(posedge clk);
                    #1;
                    e_n++;
                    if (clf_reset) e_n = eng_lat;
                end
                clf_rule  = rule_of(e_pkt);
                clf_ready = 1'b1;
            end
        end
    end

    typedef enum {M_FLUSH, M_FREE, M_ISSUE, M_WAIT, M_RESP} mphase_e;

    // Reference model, checked against the DUT on every falling edge.
    initial begin
        mphase_e       mp = M_FLUSH;
        int            m_left = 2;
        bit            m_after_to = 0;
        int            m_rr = 0;
        int            m_id = 0;
        logic [PW-1:0] m_pkt = '0;
        logic [RW-1:0] m_rule = '0;
        bit            m_to = 0;
        logic [15:0]   m_done = '0;
        logic [15:0]   m_tout = '0;
        int            m_wait = 0;
        bit            m_low = 0;
        logic [N-1:0]  exp_rdy;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mp = M_FLUSH;
                m_left = 2;
                m_after_to = 0;
                m_rr = 0;
                m_done = '0;
                m_tout = '0;
            end
            exp_rdy = (mp == M_FREE && clf_ready) ?
                      pick(req_valid, m_rr) : '0;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("clf_valid", 64'(clf_valid), 64'(mp == M_ISSUE));
            chk("clf_reset", 64'(clf_reset), 64'(mp == M_FLUSH));
            chk("resp_valid", 64'(resp_valid), 64'(mp == M_RESP));
            chk("cnt_done", 64'(cnt_done), 64'(m_done));
            chk("cnt_timeout", 64'(cnt_timeout), 64'(m_tout));
            if (mp == M_ISSUE) begin
                chk("clf_packet", 64'(clf_packet), 64'(m_pkt));
            end
            if (mp == M_RESP) begin
                chk("resp_id", 64'(resp_id), 64'(m_id));
                chk("resp_rule", 64'(resp_rule), 64'(m_rule));
                chk("resp_timeout", 64'(resp_timeout), 64'(m_to));
            end
            if (req_ready != '0) grant_q.push_back(req_ready);
            if (reset) begin
                case (mp)
                    M_FLUSH: begin
                        m_left--;
                        if (m_left == 0) mp = m_after_to ? M_RESP : M_FREE;
                    end
                    M_FREE: begin
                        if (exp_rdy != '0) begin
                            m_id  = idx_of(exp_rdy);
                            m_pkt = req_packet[m_id*PW +: PW];
                            mp    = M_ISSUE;
                        end
                    end
                    M_ISSUE: begin
                        mp = M_WAIT;
                        m_wait = 0;
                        m_low = 0;
                    end
                    M_WAIT: begin
                        if (m_low && clf_ready) begin
                            m_rule = clf_rule;
                            m_to = 0;
                            if (m_done != 16'hFFFF) m_done++;
                            mp = M_RESP;
                        end else if (m_wait == TO - 1) begin
                            m_rule = '0;
                            m_to = 1;
                            if (m_tout != 16'hFFFF) m_tout++;
                            m_after_to = 1;
                            m_left = 2;
                            mp = M_FLUSH;
                        end else begin
                            if (!clf_ready) m_low = 1;
                            m_wait++;
                        end
                    end
                    M_RESP: begin
                        if (resp_ready) begin
                            m_rr = (m_id + 1) % N;
                            m_after_to = 0;
                            mp = M_FREE;
                        end
                    end
                    default: mp = M_FLUSH;
                endcase
            end
        end
    end

    task automatic wait_grant(input int bound, output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready;
                return;
            end
        end
        chk("grant_wait_expired", 64'(0), 64'(1));
    endtask

    task automatic wait_resp(input int bound, output int nrst);
        nrst = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (resp_valid) return;
            if (clf_reset) nrst++;
        end
        chk("resp_wait_expired", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] exp_g[5];
        logic [IW-1:0] rid_q[$];
        int nrst;
        int nhs;
        int nresp;

        reset      = 1'b1;
        req_valid  = 4'b0010;
        for (int i = 0; i < N; i++) begin
            req_packet[i*PW +: PW] = 32'hA1B2_0040 + PW'(i);
        end
        clf_ready  = 1'b0;
        clf_rule   = '0;
        resp_ready = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_clf_reset", 64'(clf_reset), 64'(1));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_clf_valid", 64'(clf_valid), 64'(0));
        chk("rst_clf_packet", 64'(clf_packet), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_id", 64'(resp_id), 64'(0));
        chk("rst_resp_rule", 64'(resp_rule), 64'(0));
        chk("rst_cnt_done", 64'(cnt_done), 64'(0));

        // Release: two flush cycles, then no accept while engine busy.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_window", 64'(clf_reset), 64'(i < 2));
            chk("no_accept_busy", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #1 clf_ready = 1'b1;
        @(negedge clk);
        chk("first_grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("first_issue", 64'(clf_valid), 64'(1));
        chk("first_pkt", 64'(clf_packet), 64'(32'hA1B2_0041));
        wait_resp(50, nrst);
        chk("first_resp_id", 64'(resp_id), 64'(1));
        chk("first_resp_rule", 64'(resp_rule), 64'(16'h8041));

        // Fairness from a fresh pointer.
        do_reset();
        grant_q.delete();
        req_valid = 4'b1111;
        nhs = 0;
        for (int i = 0; i < 300 && nhs < 5; i++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                nhs++;
                rid_q.push_back(resp_id);
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        chk("fair_handshakes", 64'(nhs), 64'(5));
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("fair_grant_cnt", 64'(grant_q.size()), 64'(5));
        for (int i = 0; i < 5 && i < grant_q.size(); i++) begin
            chk("fair_grant", 64'(grant_q[i]), 64'(exp_g[i]));
            chk("fair_resp_id", 64'(rid_q[i]), 64'(idx_of(exp_g[i])));
        end
        @(negedge clk);
        chk("fair_cnt_done", 64'(cnt_done), 64'(5));

        // Backpressure on the result port.
        @(posedge clk);
        #1 resp_ready = 1'b0;
        req_valid = 4'b0100;
        wait_grant(20, g);
        chk("bp_grant", 64'(g), 64'(4'b0100));
        wait_resp(50, nrst);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'(1));
            chk("bp_id", 64'(resp_id), 64'(2));
            chk("bp_rule", 64'(resp_rule), 64'(16'h8042));
            chk("bp_no_grant", 64'(req_ready), 64'(0));
            chk("bp_no_issue", 64'(clf_valid), 64'(0));
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake", 64'(resp_valid), 64'(1));
        @(negedge clk);
        chk("bp_next_grant", 64'(req_ready), 64'(4'b0100));
        @(posedge clk);
        #1 req_valid = '0;
        wait_resp(50, nrst);
        chk("bp_cnt_done", 64'(cnt_done), 64'(7));

        // Hung engine: watchdog flush and aborted response.
        @(posedge clk);
        #1 eng_lat = 1000;
        req_valid = 4'b1000;
        wait_grant(20, g);
        chk("to_grant", 64'(g), 64'(4'b1000));
        @(posedge clk);
        #1 req_valid = '0;
        wait_resp(100, nrst);
        chk("to_flush_cycles", 64'(nrst), 64'(2));
        chk("to_flag", 64'(resp_timeout), 64'(1));
        chk("to_rule", 64'(resp_rule), 64'(0));
        chk("to_id", 64'(resp_id), 64'(3));
        chk("to_cnt_timeout", 64'(cnt_timeout), 64'(1));
        chk("to_cnt_done", 64'(cnt_done), 64'(7));

        // Done on the final watchdog cycle wins.
        @(posedge clk);
        #1 eng_lat = TO - 1;
        req_valid = 4'b0001;
        wait_grant(20, g);
        @(posedge clk);
        #1 req_valid = '0;
        wait_resp(100, nrst);
        chk("edge_flag", 64'(resp_timeout), 64'(0));
        chk("edge_rule", 64'(resp_rule), 64'(16'h8040));
        chk("edge_cnt_done", 64'(cnt_done), 64'(8));
        chk("edge_cnt_timeout", 64'(cnt_timeout), 64'(1));

        // One cycle later is too late.
        @(posedge clk);
        #1 eng_lat = TO;
        req_valid = 4'b0010;
        wait_grant(20, g);
        @(posedge clk);
        #1 req_valid = '0;
        wait_resp(100, nrst);
        chk("late_flag", 64'(resp_timeout), 64'(1));
        chk("late_id", 64'(resp_id), 64'(1));
        chk("late_cnt_timeout", 64'(cnt_timeout), 64'(2));

        // Asynchronous reset with a lookup in flight.
        @(posedge clk);
        #1 eng_lat = 8;
        req_valid = 4'b0010;
        wait_grant(20, g);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar_clf_reset", 64'(clf_reset), 64'(1));
        chk("ar_resp_valid", 64'(resp_valid), 64'(0));
        chk("ar_clf_valid", 64'(clf_valid), 64'(0));
        chk("ar_cnt_done", 64'(cnt_done), 64'(0));
        chk("ar_cnt_timeout", 64'(cnt_timeout), 64'(0));
        chk("ar_resp_rule", 64'(resp_rule), 64'(0));
        chk("ar_clf_packet", 64'(clf_packet), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        nresp = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("ar_no_stale_resp", 64'(nresp), 64'(0));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_guard: got unfinished run expected finish");
        $fatal(1);
    end

endmodule

// File: doc/classifier_scheduler.md
Name: classifier_scheduler

Overview:
Shares one classifier engine among NUM_REQ packet sources. Arbitrates requests round-robin and issues the winner's packet to the engine with a single-cycle valid pulse. Tracks the engine busy/done handshake, returns the matched rule tagged with the requester id, and recovers from a hung lookup with a watchdog that resets the engine. Sits between the ingress packet queues and the classifier.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
PKT_W, $bits(packet_s), packet width
RULE_W, $bits(rule_s), rule width
ID_W, $clog2(NUM_REQ), requester id width
TIMEOUT, 512, max cycles from issue to engine done before abort (>=4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester packet valid
req_packet  in  NUM_REQ*PKT_W  per-requester packet, slot i at [i*PKT_W +: PKT_W]
req_ready  out  NUM_REQ  one-hot accept pulse, at most one bit set
clf_packet  out  PKT_W  packet to engine
clf_valid  out  1  single-cycle issue pulse to engine
clf_ready  in  1  engine ready_to_process
clf_rule  in  RULE_W  engine matched_rule_storage
clf_reset  out  1  active-high synchronous reset to engine
resp_valid  out  1  result valid
resp_ready  in  1  result consumer ready
resp_id  out  ID_W  requester that owns the result
resp_rule  out  RULE_W  matched rule (0 on timeout)
resp_timeout  out  1  result was aborted by the watchdog
cnt_done  out  16  completed lookups, saturating
cnt_timeout  out  16  aborted lookups, saturating

Behaviour:
- Reset (reset low, async): state=FLUSH with flush count 0, clf_reset=1, rr pointer=0, all other outputs 0, timer 0, counters 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND, FLUSH.
- FLUSH: hold clf_reset=1 for 2 cycles.
  - After reset: go to IDLE.
  - After a timeout: go to RESPOND with resp_timeout=1 and resp_rule=0.
- IDLE: req_ready is combinational and asserted only when state==IDLE, clf_ready=1, and a winner exists.
  - Winner = first set req_valid scanning from index rr_ptr upward, wrapping modulo NUM_REQ.
  - On accept, register the packet and the winner id, then go to ISSUE.
  - If clf_ready=0, no accept.
- ISSUE: clf_valid=1 for exactly one cycle with clf_packet=latched packet; timer cleared. Next state is WAIT_BUSY.
- WAIT_BUSY: wait for clf_ready=0, then go to WAIT_DONE.
- WAIT_DONE: wait for clf_ready=1.
  - When it rises, capture clf_rule into resp_rule on the same edge, set resp_timeout=0, increment cnt_done, go to RESPOND.
- Watchdog: timer increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When timer==TIMEOUT-1 and the done condition is absent that cycle: increment cnt_timeout and go to FLUSH (timeout path).
  - Done on the same cycle as expiry wins.
- RESPOND: resp_valid=1 with resp_id, resp_rule, resp_timeout held stable until resp_valid && resp_ready.
  - On handshake: rr_ptr = (resp_id+1) mod NUM_REQ, go to IDLE.
  - No new request is accepted while in RESPOND (one lookup in flight).
- clf_packet holds its value outside ISSUE; clf_valid=0 in every state except ISSUE.
- Counters saturate at 16'hFFFF.
- Requesters may drop req_valid at any time before acceptance; no request is lost once req_ready has pulsed.
- Reset asserted mid-lookup: immediate return to reset state, in-flight result discarded, engine re-flushed.

Test Plan:
- Reset release: 2 cycles of clf_reset=1, then IDLE; req_valid=4'b0010 with clf_ready=1 -> req_ready=4'b0010 next cycle, clf_valid pulse 1 cycle later carrying that packet.
- Fairness: req_valid=4'b1111 held, engine model finishes in 5 cycles -> grants in order 0,1,2,3,0; resp_id matches each grant; cnt_done=5.
- Backpressure: resp_ready=0 for 10 cycles after result -> resp fields stable, req_ready stays 0, no clf_valid; resp_ready=1 -> handshake, next grant follows.
- Timeout: engine never re-raises clf_ready, TIMEOUT=16 -> FLUSH with clf_reset=1 for 2 cycles, response with resp_timeout=1 and resp_rule=0, cnt_timeout=1.
- Done/expiry collision: clf_ready rises exactly at timer==TIMEOUT-1 -> normal response, resp_timeout=0, cnt_done incremented, cnt_timeout unchanged.
- Async reset in WAIT_DONE -> outputs zero immediately, clf_reset=1, pending result never presented.
